// File: rtl/cache_set_ctrl.sv
// Set-associative tag/MESI/LRU controller: one command at a time through
// CLEAR/IDLE/LOOKUP/WB/UPDATE/RESP, with a writeback handshake for dirty lines.
module cache_set_ctrl #(
    parameter int WAYS  = 8,
    parameter int SETS  = 16,
    parameter int TAG_W = 12,
    parameter int WAY_W = $clog2(WAYS),
    parameter int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cmd,
    input  logic [SET_W-1:0] req_set,
    input  logic [TAG_W-1:0] req_tag,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [SET_W-1:0] wb_set,
    output logic [TAG_W-1:0] wb_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [WAY_W-1:0] rsp_way,
    output logic [1:0]       rsp_mesi
);
    typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_LOOKUP, ST_WB, ST_UPDATE, ST_RESP} state_t;

    localparam logic [1:0] MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11;
    localparam logic [3:0] CMD_RD = 4'd0, CMD_WR = 4'd1, CMD_IF = 4'd2;
    localparam logic [3:0] CMD_INV = 4'd3, CMD_SNP = 4'd4, CMD_CLR = 4'd8;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETS - 1);

    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tags_q, tags_d;
    logic [SETS-1:0][WAYS-1:0][1:0]       mesi_q, mesi_d;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q, age_d;

    state_t           state_q, state_d;
    logic [SET_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [3:0]       rq_cmd_q, rq_cmd_d;
    logic [SET_W-1:0] rq_set_q, rq_set_d;
    logic [TAG_W-1:0] rq_tag_q, rq_tag_d;
    logic             hit_q, hit_d;
    logic [WAY_W-1:0] way_q, way_d;

    logic             req_ready_q, req_ready_d;
    logic             wb_valid_q, wb_valid_d;
    logic [SET_W-1:0] wb_set_q, wb_set_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_hit_q, rsp_hit_d;
    logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
    logic [1:0]       rsp_mesi_q, rsp_mesi_d;

    logic             lk_hit, lk_inv;
    logic [WAY_W-1:0] lk_hit_way, lk_inv_way, lk_lru_way, lk_victim;
    logic [WAY_W-1:0] acc_age;
    logic [1:0]       new_mesi;

    // Tag compare and victim pick over the captured set
    always_comb begin
        lk_hit     = 1'b0;
        lk_inv     = 1'b0;
        lk_hit_way = '0;
        lk_inv_way = '0;
        lk_lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mesi_q[rq_set_q][w] != MESI_I && tags_q[rq_set_q][w] == rq_tag_q) begin
                lk_hit     = 1'b1;
                lk_hit_way = WAY_W'(w);
            end
            if (!lk_inv && mesi_q[rq_set_q][w] == MESI_I) begin
                lk_inv     = 1'b1;
                lk_inv_way = WAY_W'(w);
            end
            if (age_q[rq_set_q][w] == AGE_MAX) lk_lru_way = WAY_W'(w);
        end
        lk_victim = lk_inv ? lk_inv_way : lk_lru_way;
    end

    always_comb begin
        tags_d     = tags_q;
        mesi_d     = mesi_q;
        age_d      = age_q;
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rq_cmd_d   = rq_cmd_q;
        rq_set_d   = rq_set_q;
        rq_tag_d   = rq_tag_q;
        hit_d      = hit_q;
        way_d      = way_q;
        wb_set_d   = wb_set_q;
        wb_tag_d   = wb_tag_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_way_d  = rsp_way_q;
        rsp_mesi_d = rsp_mesi_q;
        acc_age    = age_q[rq_set_q][way_q];
        new_mesi   = MESI_I;

        case (state_q)
            ST_CLEAR: begin
                tags_d[clr_cnt_q] = '0;
                mesi_d[clr_cnt_q] = '0;
                for (int w = 0; w < WAYS; w++) age_d[clr_cnt_q][w] = WAY_W'(w);
                clr_cnt_d = clr_cnt_q + SET_W'(1);
                if (clr_cnt_q == SET_LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    rq_cmd_d = req_cmd;
                    rq_set_d = req_set;
                    rq_tag_d = req_tag;
                    if (req_cmd == CMD_CLR) begin
                        state_d   = ST_CLEAR;
                        clr_cnt_d = '0;
                    end else if (req_cmd <= CMD_SNP) begin
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                hit_d    = lk_hit;
                way_d    = lk_hit ? lk_hit_way : lk_victim;
                wb_set_d = rq_set_q;
                state_d  = ST_UPDATE;
                if (rq_cmd_q <= CMD_IF && !lk_hit && mesi_q[rq_set_q][lk_victim] == MESI_M) begin
                    wb_tag_d = tags_q[rq_set_q][lk_victim];
                    state_d  = ST_WB;
                end else if (rq_cmd_q == CMD_SNP && lk_hit && mesi_q[rq_set_q][lk_hit_way] == MESI_M) begin
                    wb_tag_d = rq_tag_q;
                    state_d  = ST_WB;
                end
            end
            ST_WB: begin
                if (wb_ready) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                rsp_hit_d  = hit_q;
                rsp_way_d  = '0;
                rsp_mesi_d = MESI_I;
                if (rq_cmd_q <= CMD_IF) begin
                    if (rq_cmd_q == CMD_WR)  new_mesi = MESI_M;
                    else if (hit_q)          new_mesi = mesi_q[rq_set_q][way_q];
                    else                     new_mesi = MESI_E;
                    tags_d[rq_set_q][way_q] = rq_tag_q;
                    mesi_d[rq_set_q][way_q] = new_mesi;
                    // Ages stay a permutation: only those younger than the accessed way move
                    for (int w = 0; w < WAYS; w++)
                        if (age_q[rq_set_q][w] < acc_age)
                            age_d[rq_set_q][w] = age_q[rq_set_q][w] + WAY_W'(1);
                    age_d[rq_set_q][way_q] = '0;
                    rsp_way_d  = way_q;
                    rsp_mesi_d = new_mesi;
                end else if (hit_q) begin
                    new_mesi = (rq_cmd_q == CMD_INV) ? MESI_I : MESI_S;
                    mesi_d[rq_set_q][way_q] = new_mesi;
                    rsp_way_d  = way_q;
                    rsp_mesi_d = new_mesi;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        wb_valid_d  = (state_d == ST_WB);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_set_q    <= '0;
            wb_tag_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_way_q   <= '0;
            rsp_mesi_q  <= '0;
        end else begin
            tags_q      <= tags_d;
            mesi_q      <= mesi_d;
            age_q       <= age_d;
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rq_cmd_q    <= rq_cmd_d;
            rq_set_q    <= rq_set_d;
            rq_tag_q    <= rq_tag_d;
            hit_q       <= hit_d;
            way_q       <= way_d;
            req_ready_q <= req_ready_d;
            wb_valid_q  <= wb_valid_d;
            wb_set_q    <= wb_set_d;
            wb_tag_q    <= wb_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_way_q   <= rsp_way_d;
            rsp_mesi_q  <= rsp_mesi_d;
        end
    end

    assign req_ready = req_ready_q;
    assign wb_valid  = wb_valid_q;
    assign wb_set    = wb_set_q;
    assign wb_tag    = wb_tag_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_way   = rsp_way_q;
    assign rsp_mesi  = rsp_mesi_q;
endmodule

// File: tb/tb_cache_set_ctrl.sv
// Bench for cache_set_ctrl: directed scenarios plus random traffic checked
// against a recency-list cache model.
module tb_cache_set_ctrl;
    localparam int WAYS = 8, SETS = 16, TAG_W = 12, WAY_W = 3, SET_W = 4;

    logic             clk = 1'b0, rst = 1'b1;
    logic             req_valid = 1'b0, req_ready;
    logic [3:0]       req_cmd = '0;
    logic [SET_W-1:0] req_set = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             wb_valid, wb_ready = 1'b0;
    logic [SET_W-1:0] wb_set;
    logic [TAG_W-1:0] wb_tag;
    logic             rsp_valid, rsp_ready = 1'b0, rsp_hit;
    logic [WAY_W-1:0] rsp_way;
    logic [1:0]       rsp_mesi;

    cache_set_ctrl #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_set(req_set), .req_tag(req_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_set(wb_set), .wb_tag(wb_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_way(rsp_way), .rsp_mesi(rsp_mesi)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: m_order[s][0] is the most recently used way, [WAYS-1] the least
    int m_tag[SETS][WAYS], m_mesi[SETS][WAYS], m_order[SETS][WAYS];
    logic             e_hit, e_wb;
    logic [WAY_W-1:0] e_way;
    logic [1:0]       e_mesi;
    logic [TAG_W-1:0] e_wbtag;

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w] = 0; m_mesi[s][w] = 0; m_order[s][w] = w;
            end
    endfunction

    function automatic void touch(input int s, input int a);
        int p;
        p = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == a) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = a;
    endfunction

    function automatic void predict(input int cmd, input int s, input int tag);
        int hw, vic, a, nm;
        bit hit;
        hit = 0; hw = 0; vic = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (m_mesi[s][w] != 0 && m_tag[s][w] == tag) begin hit = 1; hw = w; end
            if (vic < 0 && m_mesi[s][w] == 0) vic = w;
        end
        if (vic < 0) vic = m_order[s][WAYS-1];
        e_hit = hit; e_wb = 0; e_way = '0; e_mesi = '0; e_wbtag = '0;
        if (cmd <= 2) begin
            a = hit ? hw : vic;
            if (!hit && m_mesi[s][a] == 3) begin e_wb = 1; e_wbtag = TAG_W'(m_tag[s][a]); end
            nm = (cmd == 1) ? 3 : (hit ? m_mesi[s][a] : 2);
            m_tag[s][a] = tag; m_mesi[s][a] = nm; touch(s, a);
            e_way = WAY_W'(a); e_mesi = 2'(nm);
        end else if (hit) begin
            if (cmd == 4 && m_mesi[s][hw] == 3) begin e_wb = 1; e_wbtag = TAG_W'(tag); end
            nm = (cmd == 3) ? 0 : 1;
            m_mesi[s][hw] = nm;
            e_way = WAY_W'(hw); e_mesi = 2'(nm);
        end
    endfunction

    // Drive one command through its full handshake and check each phase
    task automatic issue(input int cmd, input int s, input int tag, input int wb_wait, input int hold);
        int  n;
        bit  bad;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait cmd=%0d: got %b want 1", cmd, req_ready);
            return;
        end
        req_valid = 1'b1; req_cmd = 4'(cmd); req_set = SET_W'(s); req_tag = TAG_W'(tag);
        @(negedge clk);
        req_valid = 1'b0;
        if (cmd == 8) begin
            n = 0; bad = 0;
            while (req_ready !== 1'b1 && n < 40) begin
                @(negedge clk); n++;
                if (rsp_valid !== 1'b0 || wb_valid !== 1'b0) bad = 1;
            end
            checks++;
            if (n != 16 || bad) begin
                errors++;
                $display("FAIL clear_sweep: got %0d cycles (spurious=%0b) want 16", n, bad);
            end
            model_reset();
            return;
        end
        if (!(cmd inside {0, 1, 2, 3, 4})) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL ignored_cmd %0d: got ready=%b rsp_valid=%b wb_valid=%b want 1 0 0",
                         cmd, req_ready, rsp_valid, wb_valid);
            end
            return;
        end
        predict(cmd, s, tag);
        @(negedge clk);
        if (e_wb) begin
            for (int i = 0; i <= wb_wait; i++) begin
                if (i > 0) @(negedge clk);
                checks++;
                if (wb_valid !== 1'b1 || wb_set !== SET_W'(s) || wb_tag !== e_wbtag || rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL wb cmd=%0d set=%0d: got valid=%b set=%0d tag=%h rsp_valid=%b want 1 %0d %h 0",
                             cmd, s, wb_valid, wb_set, wb_tag, rsp_valid, s, e_wbtag);
                end
            end
            wb_ready = 1'b1;
            @(negedge clk);
            wb_ready = 1'b0;
            checks++;
            if (wb_valid !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL wb_done: got wb_valid=%b rsp_valid=%b want 0 0", wb_valid, rsp_valid);
            end
        end else begin
            checks++;
            if (wb_valid !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL no_wb cmd=%0d set=%0d: got wb_valid=%b rsp_valid=%b want 0 0",
                         cmd, s, wb_valid, rsp_valid);
            end
        end
        @(negedge clk);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_hit !== e_hit || rsp_way !== e_way ||
                rsp_mesi !== e_mesi || req_ready !== 1'b0 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL rsp cmd=%0d set=%0d tag=%h: got v=%b hit=%b way=%0d mesi=%b rdy=%b want 1 %b %0d %b 0",
                         cmd, s, tag, rsp_valid, rsp_hit, rsp_way, rsp_mesi, req_ready, e_hit, e_way, e_mesi);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_release: got rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic wait_clear(input string name);
        int n;
        bit bad;
        n = 0; bad = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
            if (rsp_valid !== 1'b0 || wb_valid !== 1'b0) bad = 1;
        end
        checks++;
        if (n != 16 || bad) begin
            errors++;
            $display("FAIL %s_sweep: got %0d cycles (spurious=%0b) want 16", name, n, bad);
        end
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || wb_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 ||
            rsp_way !== '0 || rsp_mesi !== '0 || wb_set !== '0 || wb_tag !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b wbv=%b rspv=%b hit=%b way=%0d mesi=%b want all 0",
                     req_ready, wb_valid, rsp_valid, rsp_hit, rsp_way, rsp_mesi);
        end
        wait_clear("reset");
        for (int s = 0; s < SETS; s++) issue(0, s, int'($urandom_range(1, 4095)), 0, 0);
    endtask

    task automatic test_hit_miss();
        issue(8, 0, 0, 0, 0);
        issue(0, 3, 'h0A1, 0, 0);
        issue(0, 3, 'h0A1, 0, 1);
        issue(2, 3, 'h0A2, 0, 0);
        issue(5, 3, 'h0A1, 0, 0);
        issue(15, 3, 'h0A1, 0, 0);
        issue(2, 3, 'h0A1, 0, 0);
    endtask

    task automatic test_evict_wb();
        for (int i = 0; i < 8; i++) issue(1, 5, 'h300 + i, 0, 0);
        issue(0, 5, 'h3FF, 5, 0);
        issue(0, 5, 'h3FF, 0, 0);
    endtask

    task automatic test_snoop();
        issue(1, 2, 'h055, 0, 0);
        issue(4, 2, 'h055, 2, 3);
        issue(0, 2, 'h055, 0, 0);
        issue(4, 2, 'h056, 0, 0);
    endtask

    task automatic test_invalidate();
        for (int i = 0; i < 8; i++) issue(0, 7, 'h100 + i, 0, 0);
        issue(3, 7, 'h107, 0, 0);
        issue(3, 7, 'h1FF, 0, 0);
        issue(0, 7, 'h200, 0, 0);
    endtask

    task automatic test_reset_in_wb();
        issue(8, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) issue(1, 6, 16 + i, 0, 0);
        req_valid = 1'b1; req_cmd = 4'd0; req_set = SET_W'(6); req_tag = TAG_W'(100);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_tag !== TAG_W'(16)) begin
            errors++;
            $display("FAIL pre_reset_wb: got wb_valid=%b tag=%h want 1 010", wb_valid, wb_tag);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wb: got wb_valid=%b rsp_valid=%b req_ready=%b want 0 0 0",
                     wb_valid, rsp_valid, req_ready);
        end
        wait_clear("reset_in_wb");
        issue(0, 6, 16, 0, 0);
    endtask

    task automatic test_random();
        int r, cmd;
        for (int k = 0; k < 200; k++) begin
            r = int'($urandom_range(0, 39));
            if (r == 39)      cmd = 8;
            else if (r == 38) cmd = 9 + int'($urandom_range(0, 6));
            else              cmd = r % 5;
            issue(cmd, int'($urandom_range(0, 3)), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_hit_miss();
        test_evict_wb();
        test_snoop();
        test_invalidate();
        test_reset_in_wb();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
